cic_rate_ctrl: RTL and testbench



---
 rtl/cic_rate_ctrl_pkg.sv | 24 ++
 rtl/cic_rate_ctrl_if.sv | 27 ++
 rtl/cic_rate_ctrl_strobe_edge.sv | 21 ++
 rtl/cic_rate_ctrl.sv | 152 +++++++++++++++
 tb/tb_cic_rate_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_rate_ctrl_pkg.sv
// Shared types and constants for the CIC decimator rate sequencer.
package cic_rate_ctrl_pkg;

    localparam int unsigned RATIO_W        = 16;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned DEFAULT_RATIO  = 64;
    localparam int unsigned MIN_RATIO      = 4;
    localparam int unsigned FLUSH_CYCLES   = 4;
    localparam int unsigned SETTLE_SAMPLES = 6;
    localparam int unsigned FLUSH_CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned SETTLE_CNT_W   = $clog2(SETTLE_SAMPLES + 1);
    localparam int unsigned TIMEOUT_W      = RATIO_W + 1;

    typedef logic [RATIO_W-1:0]       ratio_t;
    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_FLUSH     = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_WAIT_EDGE = 2'd3
    } state_e;

endpackage

// File: rtl/cic_rate_ctrl_if.sv
// Control-register request channel plus decimator-side signals of the rate sequencer.
interface cic_rate_ctrl_if;
    import cic_rate_ctrl_pkg::*;

    logic    cfg_valid;
    ratio_t  cfg_ratio;
    logic    cfg_ready;
    logic    cfg_err;
    logic    cic_rst;
    ratio_t  cic_ratio;
    logic    cic_dclk;
    sample_t cic_dout;
    logic    out_valid;
    sample_t out_data;
    logic    busy;

    modport slave (
        input  cfg_valid, cfg_ratio, cic_dclk, cic_dout,
        output cfg_ready, cfg_err, cic_rst, cic_ratio, out_valid, out_data, busy
    );

    modport master (
        output cfg_valid, cfg_ratio, cic_dclk, cic_dout,
        input  cfg_ready, cfg_err, cic_rst, cic_ratio, out_valid, out_data, busy
    );

endinterface

// File: rtl/cic_rate_ctrl_strobe_edge.sv
// Rising-edge detector for the decimator output strobe (one register stage).
module cic_rate_ctrl_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic dclk_i,
    output logic rise_c_o
);

    logic dclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_q <= 1'b0;
        end else begin
            dclk_q <= dclk_i;
        end
    end

    assign rise_c_o = dclk_i & ~dclk_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate sequencer for the 5-stage CIC decimator: owns ratio and decimator reset,
// swaps ratio only at output-sample boundaries, then flushes and settles the filter.
module cic_rate_ctrl
    import cic_rate_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cic_rate_ctrl_if.slave  bus
);

    state_e                  state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [TIMEOUT_W-1:0]    to_cnt_q, to_cnt_d;
    ratio_t                  pending_q, pending_d;

    logic    cic_rst_q, cic_rst_d;
    ratio_t  cic_ratio_q, cic_ratio_d;
    logic    cfg_ready_q, cfg_ready_d;
    logic    cfg_err_q, cfg_err_d;
    logic    out_valid_q, out_valid_d;
    sample_t out_data_q, out_data_d;
    logic    busy_q, busy_d;

    logic                 rise;
    logic                 hs;
    logic                 ratio_low;
    logic                 ratio_same;
    logic [TIMEOUT_W-1:0] to_limit;
    logic                 to_expired;

    cic_rate_ctrl_strobe_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .dclk_i   (bus.cic_dclk),
        .rise_c_o (rise)
    );

    assign hs         = bus.cfg_valid & cfg_ready_q;
    assign ratio_low  = bus.cfg_ratio < RATIO_W'(MIN_RATIO);
    assign ratio_same = bus.cfg_ratio == cic_ratio_q;
    assign to_limit   = {cic_ratio_q, 1'b0} - TIMEOUT_W'(1);
    assign to_expired = to_cnt_q == to_limit;

    // State and sequencing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= '0;
            settle_cnt_q <= '0;
            to_cnt_q     <= '0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            pending_q    <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        settle_cnt_d = settle_cnt_q;
        to_cnt_d     = to_cnt_q;
        pending_d    = pending_q;
        unique case (state_q)
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (rise) begin
                    if (settle_cnt_q == SETTLE_CNT_W'(SETTLE_SAMPLES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (hs && !ratio_low && !ratio_same) begin
                    pending_d = bus.cfg_ratio;
                    to_cnt_d  = '0;
                    state_d   = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                // A stalled strobe must not wedge the sequencer, hence the timeout
                if (rise || to_expired) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d     = ST_FLUSH;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Output next values; all outputs leave through registers
    always_comb begin
        cic_rst_d   = (state_d == ST_FLUSH);
        cfg_ready_d = (state_d == ST_RUN);
        busy_d      = (state_d != ST_RUN);
        cfg_err_d   = (state_q == ST_RUN) && hs && ratio_low;
        out_valid_d = rise && ((state_q == ST_RUN) || (state_q == ST_WAIT_EDGE));
        out_data_d  = out_valid_d ? bus.cic_dout : out_data_q;
        cic_ratio_d = cic_ratio_q;
        if ((state_q == ST_WAIT_EDGE) && (state_d == ST_FLUSH)) begin
            cic_ratio_d = pending_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cic_rst_q   <= 1'b1;
            cic_ratio_q <= RATIO_W'(DEFAULT_RATIO);
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b1;
        end else begin
            cic_rst_q   <= cic_rst_d;
            cic_ratio_q <= cic_ratio_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cic_rst   = cic_rst_q;
    assign bus.cic_ratio = cic_ratio_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl with a behavioural decimator strobe whose
// period follows cic_ratio (high for the first half of each output period).
module tb_cic_rate_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cic_rate_ctrl_if bus ();

    cic_rate_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural strobe: new sample value at every rising edge of dclk
    logic              strobe_en = 1'b1;
    int                ph = 0;
    logic signed [7:0] dout_v = 8'sd3;

    always @(negedge clk) begin
        if (bus.cic_rst || !strobe_en) begin
            ph = 0;
            bus.cic_dclk = 1'b0;
        end else begin
            if (ph == 0) dout_v = dout_v + 8'sd7;
            bus.cic_dclk = (ph < int'(bus.cic_ratio) / 2);
            ph = (ph + 1 >= int'(bus.cic_ratio)) ? 0 : ph + 1;
        end
        bus.cic_dout = dout_v;
    end

    // Event counters observed at the active edge
    int   cyc = 0, rise_cnt = 0, valid_cnt = 0, acc_cnt = 0, acc_busy = 0;
    int   win_rise_ready = 0, win_valid = 0, visit_acc = 0, visit_acc_max = 0;
    logic win = 1'b0;
    logic dclk_prev = 1'b0;
    logic busy_prev = 1'b1;

    always @(posedge clk) begin
        cyc++;
        if (bus.cic_dclk && !dclk_prev) begin
            rise_cnt++;
            if (win && bus.cfg_ready) win_rise_ready++;
        end
        dclk_prev = bus.cic_dclk;
        if (bus.out_valid) begin
            valid_cnt++;
            if (win) win_valid++;
        end
        if (busy_prev && !bus.busy) visit_acc = 0;
        busy_prev = bus.busy;
        if (bus.cfg_valid && bus.cfg_ready) begin
            acc_cnt++;
            if (bus.busy) acc_busy++;
            if (win) begin
                visit_acc++;
                if (visit_acc > visit_acc_max) visit_acc_max = visit_acc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rises(input string tag, input int target);
        int b = 0;
        while (rise_cnt < target && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk(tag, 32'(rise_cnt >= target), 1);
    endtask

    task automatic measure_period(input string tag, input int exp);
        int b = 0;
        int t0;
        while (!bus.out_valid && b < 2000) begin
            @(negedge clk);
            b++;
        end
        t0 = cyc;
        @(negedge clk);
        b = 0;
        while (!bus.out_valid && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk(tag, 32'(cyc - t0), 32'(exp));
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (bus.cic_rst && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!bus.cic_rst && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, vb, ab, prev_acc, b;

        bus.cfg_valid = 1'b0;
        bus.cfg_ratio = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1. reset values, flush length, settle suppression
        chk("rst_cic_rst", 32'(bus.cic_rst), 1);
        chk("rst_cic_ratio", 32'(bus.cic_ratio), 64);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        count_high(n);
        chk("flush_len_after_rst", 32'(n), 4);
        r  = rise_cnt;
        vb = valid_cnt;
        wait_rises("wait_rise5", r + 5);
        chk("busy_before_6th_rise", 32'(bus.busy), 1);
        wait_rises("wait_rise6", r + 6);
        chk("busy_after_6th_rise", 32'(bus.busy), 0);
        chk("ready_after_6th_rise", 32'(bus.cfg_ready), 1);
        chk("settle_valid_now", 32'(bus.out_valid), 0);
        chk("settle_valid_count", 32'(valid_cnt - vb), 0);
        wait_rises("wait_rise7", r + 7);
        chk("first_valid", 32'(bus.out_valid), 1);
        chk("first_data", 32'(bus.out_data), 32'(dout_v));
        @(negedge clk);
        chk("valid_single_pulse", 32'(bus.out_valid), 0);
        chk("data_held", 32'(bus.out_data), 32'(dout_v));

        // 3. rejected ratio, then no-op ratio
        repeat (10) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 16'd2;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("err_pulse", 32'(bus.cfg_err), 1);
        chk("err_ratio_kept", 32'(bus.cic_ratio), 64);
        chk("err_stays_run", 32'(bus.busy), 0);
        @(negedge clk);
        chk("err_pulse_end", 32'(bus.cfg_err), 0);
        measure_period("period_after_err", 64);
        ab = acc_cnt;
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 16'd64;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("noop_accepted", 32'(acc_cnt - ab), 1);
        chk("noop_no_err", 32'(bus.cfg_err), 0);
        repeat (8) @(negedge clk);
        chk("noop_no_flush", 32'(bus.cic_rst), 0);
        chk("noop_ready", 32'(bus.cfg_ready), 1);

        // 4. stalled strobe: timeout after 2*64 cycles
        wait_rises("t4_sync", rise_cnt + 1);
        repeat (2) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 16'd32;
        strobe_en = 1'b0;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("wait_ready_low", 32'(bus.cfg_ready), 0);
        chk("wait_ratio_old", 32'(bus.cic_ratio), 64);
        vb = valid_cnt;
        count_low(n);
        chk("timeout_len", 32'(n), 128);
        chk("timeout_ratio_new", 32'(bus.cic_ratio), 32);
        chk("timeout_no_valid", 32'(valid_cnt - vb), 0);
        strobe_en = 1'b1;
        count_high(n);
        chk("flush_len_timeout", 32'(n), 4);
        r  = rise_cnt;
        vb = valid_cnt;
        wait_rises("t4_settle", r + 6);
        chk("t4_settle_suppressed", 32'(valid_cnt - vb + 32'(bus.out_valid)), 0);
        chk("t4_run", 32'(bus.busy), 0);
        measure_period("period_32", 32);

        // 2. edge-aligned change 32 -> 16
        wait_rises("t2_sync", rise_cnt + 1);
        repeat (10) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 16'd16;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("t2_ready_low", 32'(bus.cfg_ready), 0);
        chk("t2_ratio_old", 32'(bus.cic_ratio), 32);
        wait_rises("t2_edge", rise_cnt + 1);
        chk("t2_ratio_on_edge", 32'(bus.cic_ratio), 16);
        chk("t2_flush_on_edge", 32'(bus.cic_rst), 1);
        chk("t2_edge_forwarded", 32'(bus.out_valid), 1);
        chk("t2_edge_data", 32'(bus.out_data), 32'(dout_v));
        count_high(n);
        chk("flush_len_edge", 32'(n), 4);

        // 5a. reset during SETTLE
        r  = rise_cnt;
        vb = valid_cnt;
        wait_rises("t5_settle", r + 3);
        chk("t5_settle_suppressed", 32'(valid_cnt - vb), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5a_cic_rst", 32'(bus.cic_rst), 1);
        chk("t5a_ratio", 32'(bus.cic_ratio), 64);
        chk("t5a_busy", 32'(bus.busy), 1);
        chk("t5a_ready", 32'(bus.cfg_ready), 0);
        chk("t5a_out_data", 32'(bus.out_data), 0);
        count_high(n);
        r = rise_cnt;
        wait_rises("t5a_run", r + 6);
        chk("t5a_back_in_run", 32'(bus.busy), 0);

        // 5b. reset during WAIT_EDGE discards the pending ratio
        repeat (3) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 16'd20;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk("t5b_in_wait", 32'(bus.cfg_ready), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5b_cic_rst", 32'(bus.cic_rst), 1);
        chk("t5b_ratio", 32'(bus.cic_ratio), 64);
        chk("t5b_busy", 32'(bus.busy), 1);
        count_high(n);
        r = rise_cnt;
        wait_rises("t5b_run", r + 6);
        chk("t5b_pending_lost", 32'(bus.cic_ratio), 64);
        chk("t5b_back_in_run", 32'(bus.busy), 0);

        // 6. cfg_valid held high with alternating ratios
        ab = acc_cnt;
        prev_acc = acc_cnt;
        win = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_ratio = 16'd16;
        b = 0;
        while (acc_cnt - ab < 3 && b < 5000) begin
            @(negedge clk);
            b++;
            if (acc_cnt != prev_acc) begin
                prev_acc = acc_cnt;
                bus.cfg_ratio = (bus.cfg_ratio == 16'd16) ? 16'd48 : 16'd16;
            end
        end
        bus.cfg_valid = 1'b0;
        chk("t6_accepts", 32'(acc_cnt - ab), 3);
        b = 0;
        while (bus.busy && b < 5000) begin
            @(negedge clk);
            b++;
        end
        win = 1'b0;
        chk("t6_final_run", 32'(bus.busy), 0);
        chk("t6_final_ratio", 32'(bus.cic_ratio), 16);
        chk("t6_one_per_visit", 32'(visit_acc_max), 1);
        chk("t6_no_busy_accept", 32'(acc_busy), 0);
        chk("t6_no_lost_samples", 32'(win_valid), 32'(win_rise_ready + 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
